// File: rtl/product_streamer.sv
// Buffers eight 32-bit products and streams them out LSB-byte-first over a valid/ready port.
// Optional build macro PRODUCT_STREAM_CHECKSUM_EN appends an XOR checksum byte to each frame.
module product_streamer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [31:0] data_in,
    input  logic        start,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_slot [8];
    logic        r_overrun;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [7:0]  w_data;
    logic        w_last;
    logic        w_xfer;
    logic        w_launch;

    assign w_xfer   = (r_state == SEND) && out_ready;
    assign w_launch = (r_state == IDLE) && start;
    assign w_word   = r_slot[r_cnt[4:2]];
    assign w_byte   = w_word[{r_cnt[1:0], 3'b000} +: 8];

`ifdef PRODUCT_STREAM_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_sel;

    // r_csum_sel marks the extra 33rd beat once all 32 data bytes have gone out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum     <= 8'h00;
            r_csum_sel <= 1'b0;
        end else if (w_launch) begin
            r_csum     <= 8'h00;
            r_csum_sel <= 1'b0;
        end else if (w_xfer && !r_csum_sel) begin
            r_csum     <= r_csum ^ w_byte;
            r_csum_sel <= (r_cnt == 5'd31);
        end
    end

    assign w_last = r_csum_sel;
    assign w_data = r_csum_sel ? r_csum : w_byte;
`else
    assign w_last = (r_cnt == 5'd31);
    assign w_data = w_byte;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = SEND;
            SEND:    if (w_xfer && w_last) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_launch) begin
                r_cnt <= 5'd0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 5'd1;
            end
            if (wr && busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Slots are frozen while streaming; a same-cycle wr+start in IDLE still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 32'h0;
            end
        end else if (wr && !busy) begin
            r_slot[addr] <= data_in;
        end
    end

    assign busy      = (r_state == SEND);
    assign done      = (r_state == FIN);
    assign out_valid = busy;
    assign out_data  = busy ? w_data : 8'h00;
    assign out_last  = busy && w_last;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_product_streamer.sv
// Self-checking bench for product_streamer: table-driven frame checks plus reset,
// overrun, ignored-restart and write-with-start sequences.
module tb_product_streamer;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic        start;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overrun;

`ifdef PRODUCT_STREAM_CHECKSUM_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    typedef struct {
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_done;
    } vec_t;

    vec_t        vecs [200];
    int          n_vec;
    logic [31:0] m_slot [8];
    int          n_checks;
    int          n_fail;

    product_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        logic [31:0] w;
        logic [7:0]  c;
        if (idx < 32) begin
            w = m_slot[idx / 4] >> (8 * (idx % 4));
            return w[7:0];
        end
        c = 8'h00;
        for (int j = 0; j < 32; j++) begin
            w = m_slot[j / 4] >> (8 * (j % 4));
            c = c ^ w[7:0];
        end
        return c;
    endfunction

    // mode 0: ready always high; mode 1: ready follows 1,0,0,1 repeating
    task automatic build_table(input int mode);
        int idx;
        int k;
        logic rdy;
        idx = 0;
        k   = 0;
        while (idx < NB) begin
            rdy = (mode == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
            vecs[k] = '{rdy, 1'b1, exp_byte(idx), (idx == NB - 1), 1'b0};
            if (rdy) idx++;
            k++;
        end
        vecs[k]     = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[k + 1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        n_vec = k + 2;
    endtask

    // Entered just after a negedge with the DUT already in SEND.
    task automatic run_table(input string tag, input int inject_at);
        for (int k = 0; k < n_vec; k++) begin
            start     = (k == inject_at);
            wr        = (k == inject_at);
            addr      = 3'd2;
            data_in   = 32'hDEADBEEF;
            out_ready = vecs[k].ready;
            #1;
            check({tag, "_valid"}, 32'(out_valid), 32'(vecs[k].exp_valid));
            check({tag, "_data"},  32'(out_data),  32'(vecs[k].exp_data));
            check({tag, "_last"},  32'(out_last),  32'(vecs[k].exp_last));
            check({tag, "_busy"},  32'(busy),      32'(vecs[k].exp_valid));
            check({tag, "_done"},  32'(done),      32'(vecs[k].exp_done));
            @(negedge clk);
        end
        start = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic wr_slot(input int a, input logic [31:0] d);
        wr      = 1'b1;
        addr    = 3'(a);
        data_in = d;
        @(negedge clk);
        wr = 1'b0;
        m_slot[a] = d;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},   32'(out_valid), 32'd0);
        check({tag, "_data"},    32'(out_data),  32'd0);
        check({tag, "_last"},    32'(out_last),  32'd0);
        check({tag, "_busy"},    32'(busy),      32'd0);
        check({tag, "_done"},    32'(done),      32'd0);
        check({tag, "_overrun"}, 32'(overrun),   32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        wr        = 1'b0;
        addr      = 3'd0;
        data_in   = 32'h0;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) m_slot[i] = 32'h0;

        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            wr_slot(i, {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
        end
        check("idle_no_stream", 32'(out_valid), 32'd0);

        // Full frame with ready held high
        out_ready = 1'b1;
        start_pulse();
        build_table(0);
        run_table("burst", -1);

        // Back-pressure: ready 1,0,0,1 repeating
        start_pulse();
        build_table(1);
        run_table("stall", -1);

        // Restart and write while busy at byte 5: both ignored, overrun set
        check("overrun_pre", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        start_pulse();
        build_table(0);
        run_table("restart", 5);
        check("overrun_set", 32'(overrun), 32'd1);

        // Write to slot 7 in the same cycle as start
        wr        = 1'b1;
        addr      = 3'd7;
        data_in   = 32'h12345678;
        start     = 1'b1;
        m_slot[7] = 32'h12345678;
        @(negedge clk);
        wr    = 1'b0;
        start = 1'b0;
        build_table(0);
        check("wrstart_b28", 32'(vecs[28].exp_data), 32'h78);
        check("wrstart_b31", 32'(vecs[31].exp_data), 32'h12);
        run_table("wrstart", -1);

        // Reset mid-stream
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_slot[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid | done), 32'd0);
        end
        start_pulse();
        build_table(0);
        run_table("replay", -1);

        // Single nonzero byte: checksum byte (when present) equals 0xFF
        wr_slot(0, 32'h000000FF);
        start_pulse();
        build_table(0);
        run_table("csum", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
